// File: rtl/rng_byte_server_if.sv
`default_nettype none
// ============================================================================
// Module   : rng_byte_server_if
// Brief    : Request, rng accumulator and byte-stream signals of rng_byte_server.
// Revision : 1.0 - initial release
// ============================================================================
interface rng_byte_server_if #(
    parameter int BYTES = 8,
    parameter int LEN_W = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic [LEN_W-1:0]     req_len;
    logic                 flush;
    logic                 rng_start;
    logic [8*BYTES-1:0]   rng_result;
    logic                 rng_valid;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_last;
    logic                 out_ready;
    logic                 busy;

    // Server side
    modport slave (
        input  req_valid, req_len, flush, rng_result, rng_valid, out_ready,
        output req_ready, rng_start, out_data, out_valid, out_last, busy
    );

    // Requester / rng / sink side
    modport master (
        output req_valid, req_len, flush, rng_result, rng_valid, out_ready,
        input  req_ready, rng_start, out_data, out_valid, out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/rng_byte_server.sv
`default_nettype none
// ============================================================================
// Module   : rng_byte_server
// Brief    : Fetches BYTES-wide rng words on demand and streams them LSB-first
//            as a valid/ready byte stream with a last flag.
// Revision : 1.0 - initial release
// ============================================================================
module rng_byte_server #(
    parameter int BYTES   = 8,
    parameter int MAX_REQ = 64,
    parameter int LEN_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rng_byte_server_if.slave      bus
);

    localparam int c_rem_w = $clog2(MAX_REQ + 1);
    localparam int c_idx_w = $clog2(BYTES) + 1;
    localparam int c_cmp_w = (LEN_W > c_rem_w) ? LEN_W : c_rem_w;
    localparam logic [c_cmp_w-1:0] c_max_req = c_cmp_w'(MAX_REQ);
    localparam logic [c_idx_w-1:0] c_idx_end = c_idx_w'(BYTES);
    localparam logic [c_rem_w-1:0] c_rem_one = c_rem_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [BYTES-1:0][7:0]    r_buf, w_buf_nxt;
    logic [c_rem_w-1:0]       r_rem, w_rem_nxt;
    logic [c_idx_w-1:0]       r_idx, w_idx_nxt;
    logic                     r_rng_valid_q;
    logic                     r_rng_start, w_rng_start_nxt;
    logic                     r_out_valid, w_out_valid_nxt;
    logic                     r_out_last, w_out_last_nxt;
    logic [7:0]               r_out_data, w_out_data_nxt;
    logic                     r_busy;
    logic                     r_req_ready;

    logic [c_cmp_w-1:0]       w_len_ext;
    logic [c_rem_w-1:0]       w_len_clamped;
    logic [c_idx_w-1:0]       w_idx_inc;
    logic [c_rem_w-1:0]       w_rem_dec;
    logic [7:0]               w_next_byte;
    logic                     w_rise;

    assign w_len_ext     = c_cmp_w'(bus.req_len);
    assign w_len_clamped = (w_len_ext > c_max_req) ? c_rem_w'(MAX_REQ) : c_rem_w'(w_len_ext);
    assign w_idx_inc     = r_idx + c_idx_w'(1);
    assign w_rem_dec     = r_rem - c_rem_one;
    // Only a fresh rise means a new word; a level left over from the previous fetch is stale.
    assign w_rise        = bus.rng_valid && !r_rng_valid_q;

    always_comb begin
        w_next_byte = 8'h00;
        for (int k = 0; k < BYTES; k++) begin
            if (w_idx_inc == c_idx_w'(k)) begin
                w_next_byte = r_buf[k];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_buf_nxt       = r_buf;
        w_rem_nxt       = r_rem;
        w_idx_nxt       = r_idx;
        w_rng_start_nxt = 1'b0;
        w_out_valid_nxt = r_out_valid;
        w_out_last_nxt  = r_out_last;
        w_out_data_nxt  = r_out_data;

        if (bus.flush) begin
            w_state_nxt     = ST_IDLE;
            w_buf_nxt       = '0;
            w_rem_nxt       = '0;
            w_idx_nxt       = '0;
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
            w_out_data_nxt  = 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        w_rem_nxt = w_len_clamped;
                        if (w_len_clamped != '0) begin
                            w_state_nxt     = ST_FETCH;
                            w_rng_start_nxt = 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    w_state_nxt = ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_rise) begin
                        w_buf_nxt       = bus.rng_result;
                        w_idx_nxt       = '0;
                        w_state_nxt     = ST_SEND;
                        w_out_valid_nxt = 1'b1;
                        w_out_data_nxt  = bus.rng_result[7:0];
                        w_out_last_nxt  = (r_rem == c_rem_one);
                    end
                end
                ST_SEND: begin
                    if (bus.out_ready) begin
                        w_rem_nxt = w_rem_dec;
                        w_idx_nxt = w_idx_inc;
                        if (w_rem_dec == '0) begin
                            w_state_nxt     = ST_IDLE;
                            w_buf_nxt       = '0;
                            w_out_valid_nxt = 1'b0;
                            w_out_last_nxt  = 1'b0;
                            w_out_data_nxt  = 8'h00;
                        end else if (w_idx_inc == c_idx_end) begin
                            w_state_nxt     = ST_FETCH;
                            w_rng_start_nxt = 1'b1;
                            w_out_valid_nxt = 1'b0;
                            w_out_last_nxt  = 1'b0;
                        end else begin
                            w_out_data_nxt  = w_next_byte;
                            w_out_last_nxt  = (w_rem_dec == c_rem_one);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_buf         <= '0;
            r_rem         <= '0;
            r_idx         <= '0;
            r_rng_valid_q <= 1'b0;
            r_rng_start   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_data    <= 8'h00;
            r_busy        <= 1'b0;
            r_req_ready   <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_buf         <= w_buf_nxt;
            r_rem         <= w_rem_nxt;
            r_idx         <= w_idx_nxt;
            r_rng_valid_q <= bus.rng_valid;
            r_rng_start   <= w_rng_start_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_last    <= w_out_last_nxt;
            r_out_data    <= w_out_data_nxt;
            r_busy        <= (w_state_nxt != ST_IDLE);
            r_req_ready   <= (w_state_nxt == ST_IDLE);
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rng_start = r_rng_start;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rng_byte_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_rng_byte_server
// Brief    : Scoreboard bench for rng_byte_server with an rng timing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rng_byte_server;
    localparam int BYTES   = 8;
    localparam int MAX_REQ = 64;
    localparam int LEN_W   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rng_byte_server_if #(.BYTES(BYTES), .LEN_W(LEN_W)) bus ();

    rng_byte_server #(.BYTES(BYTES), .MAX_REQ(MAX_REQ), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Word k, byte j = 0x11*(j+1) + k ; word 0 is 0x8877665544332211
    function automatic logic [7:0] word_byte(input int k, input int j);
        return 8'((j + 1) * 17 + k);
    endfunction

    // rng model: valid drops on start, rises BYTES cycles after start is sampled
    int                 n_starts = 0;
    int                 rng_cnt  = 0;
    int                 rng_idx  = 0;
    logic               m_valid  = 1'b0;
    logic [8*BYTES-1:0] m_result = '0;
    assign bus.rng_valid  = m_valid;
    assign bus.rng_result = m_result;
    always @(posedge clk) begin
        if (bus.rng_start) begin
            m_valid  <= 1'b0;
            rng_cnt  <= BYTES;
            rng_idx  <= n_starts;
            n_starts <= n_starts + 1;
        end else if (rng_cnt != 0) begin
            rng_cnt <= rng_cnt - 1;
            if (rng_cnt == 1) begin
                m_valid <= 1'b1;
                for (int j = 0; j < BYTES; j++) m_result[8*j +: 8] <= word_byte(rng_idx, j);
            end
        end
    end

    int   rdy_mode = 0;
    logic man_rdy  = 1'b0;
    logic rnd_rdy  = 1'b1;
    always @(negedge clk) rnd_rdy <= 1'($urandom_range(0, 1));
    assign bus.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? rnd_rdy : man_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: {last, data}
    logic [8:0] exp_q[$];

    // Monitor samples 1 time unit before each rising edge
    logic       prev_stall = 1'b0;
    logic       prev_lasths = 1'b0;
    logic       prev_ov = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    int         ov_rise_cyc = 0;
    always @(negedge clk) begin
        logic [8:0] e;
        #4;
        if (!rst_n) begin
            prev_stall  = 1'b0;
            prev_lasths = 1'b0;
            prev_ov     = 1'b0;
            exp_q.delete();
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(bus.out_valid), 64'd1);
                check("stall_data", 64'(bus.out_data), 64'(prev_data));
                check("stall_last", 64'(bus.out_last), 64'(prev_last));
            end
            if (prev_lasths) begin
                check("ready_after_last", 64'(bus.req_ready), 64'd1);
                check("idle_after_last", 64'(bus.busy), 64'd0);
            end
            if (bus.out_valid && !prev_ov) ov_rise_cyc = cyc + 1;
            prev_lasths = 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_byte actual=%0h required=none", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte_data", 64'(bus.out_data), 64'(e[7:0]));
                    check("byte_last", 64'(bus.out_last), 64'(e[8]));
                end
                prev_lasths = bus.out_last;
            end
            prev_stall = bus.out_valid && !bus.out_ready && !bus.flush;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
            prev_ov    = bus.out_valid;
        end
    end

    task automatic push_req(input int len, input int nexp);
        int n;
        int k;
        n = (len > MAX_REQ) ? MAX_REQ : len;
        k = n_starts;
        for (int i = 0; i < nexp; i++)
            exp_q.push_back({(i == n - 1), word_byte(k + i / BYTES, i % BYTES)});
    endtask

    task automatic send_req(input int len, input logic with_flush, output int acc);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_len   = LEN_W'(len);
        bus.flush     = with_flush;
        #4;
        acc = cyc + 1;
        check("req_ready_on_issue", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while (i < budget && !(exp_q.size() == 0 && bus.req_ready)) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (i >= budget) begin
            failures++;
            $display("FAIL %s timeout pending=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic wait_out_valid(input string name);
        int i;
        i = 0;
        while (i < 60 && !bus.out_valid) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (i >= 60) begin
            failures++;
            $display("FAIL %s out_valid_timeout actual=0 required=1", name);
        end
    endtask

    task automatic watch_quiet(input int ncyc, output logic seen_busy, output logic seen_ov);
        seen_busy = 1'b0;
        seen_ov   = 1'b0;
        repeat (ncyc) begin
            @(negedge clk);
            seen_busy |= bus.busy;
            seen_ov   |= bus.out_valid;
        end
    endtask

    initial begin
        int acc;
        int s0;
        logic sb;
        logic so;
        bus.req_valid = 1'b0;
        bus.req_len   = '0;
        bus.flush     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_rng_start", 64'(bus.rng_start), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        check("rst_out_last", 64'(bus.out_last), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_req_ready", 64'(bus.req_ready), 64'd1);
        check("rel_busy", 64'(bus.busy), 64'd0);

        // Three bytes from word 0, latency and single fetch
        s0 = n_starts;
        push_req(3, 3);
        send_req(3, 1'b0, acc);
        wait_idle("len3", 200);
        check("len3_starts", 64'(n_starts - s0), 64'd1);
        check("len3_latency", 64'(ov_rise_cyc - acc), 64'(BYTES + 3));

        // 20 bytes over three words, then a fresh word for one byte
        s0 = n_starts;
        push_req(20, 20);
        send_req(20, 1'b0, acc);
        wait_idle("len20", 400);
        check("len20_starts", 64'(n_starts - s0), 64'd3);
        s0 = n_starts;
        push_req(1, 1);
        send_req(1, 1'b0, acc);
        wait_idle("len1", 200);
        check("len1_starts", 64'(n_starts - s0), 64'd1);

        // Backpressure
        rdy_mode = 1;
        s0 = n_starts;
        push_req(16, 16);
        send_req(16, 1'b0, acc);
        wait_idle("len16_bp", 800);
        check("len16_starts", 64'(n_starts - s0), 64'd2);
        rdy_mode = 0;

        // Zero-length and clamped requests
        s0 = n_starts;
        send_req(0, 1'b0, acc);
        watch_quiet(20, sb, so);
        check("len0_busy", 64'(sb), 64'd0);
        check("len0_starts", 64'(n_starts - s0), 64'd0);
        check("len0_ready", 64'(bus.req_ready), 64'd1);
        s0 = n_starts;
        push_req(200, MAX_REQ);
        send_req(200, 1'b0, acc);
        wait_idle("len200", 2000);
        check("len200_starts", 64'(n_starts - s0), 64'd8);

        // Flush in SEND after two bytes
        rdy_mode = 2;
        man_rdy  = 1'b0;
        push_req(8, 2);
        send_req(8, 1'b0, acc);
        wait_out_valid("flush_send");
        man_rdy = 1'b1;
        repeat (2) @(negedge clk);
        man_rdy   = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("fsend_out_valid", 64'(bus.out_valid), 64'd0);
        check("fsend_req_ready", 64'(bus.req_ready), 64'd1);
        check("fsend_pending", 64'(exp_q.size()), 64'd0);
        rdy_mode = 0;
        s0 = n_starts;
        push_req(8, 8);
        send_req(8, 1'b0, acc);
        wait_idle("after_fsend", 200);
        check("after_fsend_starts", 64'(n_starts - s0), 64'd1);

        // Flush in WAIT; the late rise of the aborted word is ignored
        s0 = n_starts;
        send_req(4, 1'b0, acc);
        repeat (2) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("fwait_busy", 64'(bus.busy), 64'd0);
        watch_quiet(15, sb, so);
        check("fwait_quiet", 64'(so), 64'd0);
        check("fwait_starts", 64'(n_starts - s0), 64'd1);
        push_req(4, 4);
        send_req(4, 1'b0, acc);
        wait_idle("after_fwait", 200);

        // Flush on the accept cycle discards the request
        s0 = n_starts;
        send_req(5, 1'b1, acc);
        watch_quiet(15, sb, so);
        check("facc_busy", 64'(sb), 64'd0);
        check("facc_starts", 64'(n_starts - s0), 64'd0);

        // Asynchronous reset mid-SEND
        rdy_mode = 2;
        man_rdy  = 1'b0;
        send_req(8, 1'b0, acc);
        wait_out_valid("rst_send");
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_req_ready", 64'(bus.req_ready), 64'd1);
        check("arst_out_data", 64'(bus.out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-WAIT; rng keeps running and later rises
        rdy_mode = 0;
        send_req(8, 1'b0, acc);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_wait_busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_quiet(15, sb, so);
        check("arst_wait_quiet", 64'(so), 64'd0);
        s0 = n_starts;
        push_req(2, 2);
        send_req(2, 1'b0, acc);
        wait_idle("after_arst", 200);
        check("after_arst_starts", 64'(n_starts - s0), 64'd1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
